// File: rtl/shared_resource_pipe_pkg.sv
// Shared types and widths for the shared resource pipe.
// Width macros fall back to local defaults when no project-wide defines are supplied.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif
`ifndef NUM_PRODUCERS
`define NUM_PRODUCERS 4
`endif

package shared_resource_pipe_pkg;

  localparam int DATA_W = `DATA_WIDTH;
  localparam int ID_W   = `ID_WIDTH;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } stage_t;

  // Next round-robin start position after index idx won.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping mod N.
// The pointer is owned by the parent so it only moves on an actual transfer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (en && !found && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_resource_pipe.sv
// Round-robin shared resource feeding a fixed-depth pipeline toward a consumer with no backpressure.
// A global stall freezes the pipe and blocks grants; the output stage self-clears to avoid repeat pulses.
module shared_resource_pipe
  import shared_resource_pipe_pkg::*;
#(
  parameter int NUM_PRODUCERS = `NUM_PRODUCERS,
  parameter int PIPE_DEPTH    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PRODUCERS-1:0]        req_valid,
  input  logic [NUM_PRODUCERS*DATA_W-1:0] req_data,
  output logic [NUM_PRODUCERS-1:0]        req_ready,
  input  logic                            stall,
  output logic [DATA_W-1:0]               out_data,
  output logic [ID_W-1:0]                 out_id,
  output logic                            out_valid
);

  localparam int PTR_W = (NUM_PRODUCERS > 1) ? $clog2(NUM_PRODUCERS) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             transfer;
  logic [DATA_W-1:0] txn_data;
  stage_t           s [PIPE_DEPTH];

  rr_arbiter #(.N(NUM_PRODUCERS), .PTR_W(PTR_W)) u_arb (
    .req     (req_valid),
    .en      (!stall),
    .ptr     (ptr),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign transfer = |req_ready;
  assign txn_data = req_data[gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= PTR_W'(wrap_inc(int'(gnt_idx), NUM_PRODUCERS));
    end
  end

  // Payload only moves alongside a valid, so out_data/out_id keep their last values between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        s[k] <= '0;
      end
    end else if (!stall) begin
      s[0].valid <= transfer;
      if (transfer) begin
        s[0].data <= txn_data;
        s[0].id   <= ID_W'(gnt_idx);
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        s[k].valid <= s[k-1].valid;
        if (s[k-1].valid) begin
          s[k].data <= s[k-1].data;
          s[k].id   <= s[k-1].id;
        end
      end
    end else begin
      s[PIPE_DEPTH-1].valid <= 1'b0;
    end
  end

  assign out_valid = s[PIPE_DEPTH-1].valid;
  assign out_data  = s[PIPE_DEPTH-1].data;
  assign out_id    = s[PIPE_DEPTH-1].id;

endmodule

// File: tb/tb_shared_resource_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a per-transaction latency model.
// The model tracks each accepted transaction with a count of unstalled edges still to go.
module tb_shared_resource_pipe;
  import shared_resource_pipe_pkg::*;

  localparam int N = 4;
  localparam int D = 2;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                left;
  } txn_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N*DATA_W-1:0] req_data = '0;
  logic [N-1:0]        req_ready;
  logic                stall = 1'b0;
  logic [DATA_W-1:0]   out_data;
  logic [ID_W-1:0]     out_id;
  logic                out_valid;

  int compared = 0;
  int mismatched = 0;

  txn_t              q[$];
  int                m_ptr = 0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_id = 0;
  logic              m_valid = 1'b0;
  logic [N-1:0]      seen_ready;

  shared_resource_pipe #(.NUM_PRODUCERS(N), .PIPE_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one cycle of inputs, check grant, clock, then check outputs against the model.
  task automatic applyStimulus(input logic [N-1:0] v, input logic st, input logic rs,
                               input logic [N*DATA_W-1:0] d);
    logic [N-1:0] exp_ready;
    int           win;
    req_valid = v;
    stall     = st;
    reset     = rs;
    req_data  = d;
    if (rs) begin
      q.delete();
      m_ptr   = 0;
      m_data  = '0;
      m_id    = 0;
      m_valid = 1'b0;
    end
    exp_ready = '0;
    win = -1;
    if (!st && v != '0) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_ready[win] = 1'b1;
    end
    #1;
    seen_ready = req_ready;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    m_valid = 1'b0;
    if (!rs && !st) begin
      for (int i = 0; i < q.size(); i++) q[i].left--;
      if (win >= 0) begin
        q.push_back('{id: win, data: d[win*DATA_W +: DATA_W], left: D - 1});
        m_ptr = (win + 1) % N;
      end
      if (q.size() > 0 && q[0].left == 0) begin
        m_valid = 1'b1;
        m_data  = q[0].data;
        m_id    = q[0].id;
        void'(q.pop_front());
      end
    end
    #1;
    checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
    checkOutput("out_data", 64'(out_data), 64'(m_data));
    checkOutput("out_id", 64'(out_id), 64'(m_id));
  endtask

  function automatic logic [N*DATA_W-1:0] rand_data();
    logic [N*DATA_W-1:0] r;
    for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  initial begin
    logic [N*DATA_W-1:0] d;
    logic [N-1:0] rot;

    // Reset state and mid-stream reset with two transactions in flight.
    applyStimulus('0, 1'b0, 1'b1, '0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    applyStimulus(4'b0011, 1'b0, 1'b0, rand_data());
    applyStimulus(4'b0011, 1'b0, 1'b0, rand_data());
    for (int c = 0; c < 4; c++) applyStimulus(4'b1111, 1'b0, 1'b1, rand_data());
    for (int c = 0; c < 3; c++) applyStimulus('0, 1'b0, 1'b0, rand_data());
    applyStimulus(4'b1111, 1'b0, 1'b0, rand_data());
    checkOutput("ptr_restart", 64'(seen_ready), 64'(4'b0001));

    // Single transfer latency and exact pulse width.
    applyStimulus('0, 1'b0, 1'b1, '0);
    d = rand_data();
    d[DATA_W-1:0] = DATA_W'(8'hA5);
    applyStimulus(4'b0001, 1'b0, 1'b0, d);
    checkOutput("lat_early", 64'(out_valid), 64'(0));
    applyStimulus('0, 1'b0, 1'b0, rand_data());
    checkOutput("lat_valid", 64'(out_valid), 64'(1));
    checkOutput("lat_data", 64'(out_data), 64'(8'hA5));
    checkOutput("lat_id", 64'(out_id), 64'(0));
    applyStimulus('0, 1'b0, 1'b0, rand_data());
    checkOutput("lat_once", 64'(out_valid), 64'(0));
    checkOutput("lat_hold", 64'(out_data), 64'(8'hA5));

    // All producers valid: strict rotation.
    applyStimulus('0, 1'b0, 1'b1, '0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, rand_data());
      rot = 4'b0001 << (c % 4);
      checkOutput("rotation", 64'(seen_ready), 64'(rot));
    end
    for (int c = 0; c < D; c++) applyStimulus('0, 1'b0, 1'b0, rand_data());

    // Sparse requesters wrap past the idle ones.
    applyStimulus('0, 1'b0, 1'b1, '0);
    applyStimulus(4'b1010, 1'b0, 1'b0, rand_data());
    checkOutput("sparse_1", 64'(seen_ready), 64'(4'b0010));
    applyStimulus(4'b1010, 1'b0, 1'b0, rand_data());
    checkOutput("sparse_3", 64'(seen_ready), 64'(4'b1000));
    applyStimulus(4'b1010, 1'b0, 1'b0, rand_data());
    checkOutput("sparse_wrap", 64'(seen_ready), 64'(4'b0010));
    for (int c = 0; c < D; c++) applyStimulus('0, 1'b0, 1'b0, rand_data());

    // One transaction held in the first stage across three stalled edges.
    applyStimulus('0, 1'b0, 1'b1, '0);
    applyStimulus(4'b0100, 1'b0, 1'b0, rand_data());
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, rand_data());
      checkOutput("stall_ready", 64'(seen_ready), 64'(0));
      checkOutput("stall_quiet", 64'(out_valid), 64'(0));
    end
    applyStimulus('0, 1'b0, 1'b0, rand_data());
    checkOutput("stall_release", 64'(out_valid), 64'(1));
    checkOutput("stall_id", 64'(out_id), 64'(2));
    applyStimulus('0, 1'b0, 1'b0, rand_data());
    checkOutput("stall_single", 64'(out_valid), 64'(0));

    // Random traffic with occasional stalls and rare resets.
    applyStimulus('0, 1'b0, 1'b1, '0);
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 999) == 0),
                    rand_data());
    end
    for (int c = 0; c < D + 2; c++) applyStimulus('0, 1'b0, 1'b0, rand_data());
    checkOutput("drained", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
